// File: rtl/fwd_pkg.sv
// ============================================================================
// Module : fwd_pkg
// Brief  : Shared types for the operand-forwarding / load-use hazard unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fwd_pkg;

  // Record tag field is sized for the widest supported register index;
  // narrower indices are zero-extended on entry.
  localparam int FWD_TAG_MAX = 8;
  localparam logic [FWD_TAG_MAX-1:0] ZERO_TAG = '0;

  typedef struct packed {
    logic                   valid;
    logic [FWD_TAG_MAX-1:0] tag;
    logic                   vf;
    logic                   is_load;
  } dest_rec_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_S1 = 2'd1,
    FWD_S2 = 2'd2
  } fwd_src_e;

  function automatic logic rec_hit(input dest_rec_t              rec,
                                   input logic                   en,
                                   input logic [FWD_TAG_MAX-1:0] tag,
                                   input logic                   vf);
    return en & rec.valid & (rec.tag == tag) & (rec.vf == vf) & (tag != ZERO_TAG);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_src_sel.sv
// ============================================================================
// Module : fwd_src_sel
// Brief  : One decode operand: compare against S1/S2 records, 3:1 priority mux.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fwd_src_sel
  import fwd_pkg::*;
#(
  parameter int DATA_W = 128
) (
  input  logic                   src_en_i,
  input  logic [FWD_TAG_MAX-1:0] src_tag_i,
  input  logic                   src_vf_i,
  input  logic [DATA_W-1:0]      rf_data_i,
  input  dest_rec_t              s1_rec_i,
  input  dest_rec_t              s2_rec_i,
  input  logic [DATA_W-1:0]      s1_res_i,
  input  logic [DATA_W-1:0]      s2_res_i,
  output logic [DATA_W-1:0]      data_o,
  output fwd_src_e               sel_o,
  output logic                   s1_load_hit_o
);

  logic w_hit1;
  logic w_hit2;
  logic w_unused_s2_load;

  assign w_hit1 = rec_hit(s1_rec_i, src_en_i, src_tag_i, src_vf_i);
  assign w_hit2 = rec_hit(s2_rec_i, src_en_i, src_tag_i, src_vf_i);

  assign s1_load_hit_o    = w_hit1 & s1_rec_i.is_load;
  assign w_unused_s2_load = s2_rec_i.is_load;

  // S1 holds the younger writer, so it must win over S2 for the same tag.
  always_comb begin
    sel_o  = FWD_RF;
    data_o = rf_data_i;
    if (w_hit1) begin
      sel_o  = FWD_S1;
      data_o = s1_res_i;
    end else if (w_hit2) begin
      sel_o  = FWD_S2;
      data_o = s2_res_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
// ============================================================================
// Module : fwd_hazard_unit
// Brief  : S1/S2 destination tracking, operand forwarding and load-use stall.
//          Optional perf counters enabled by defining FWD_PERF_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int TAG_W  = 4,
  parameter int NSRC   = 3,
  parameter int CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   id_valid,
  input  logic [NSRC-1:0]        id_src_en,
  input  logic [NSRC*TAG_W-1:0]  id_src_tag,
  input  logic [NSRC-1:0]        id_src_vf,
  input  logic [NSRC*DATA_W-1:0] id_src_data,
  input  logic                   id_dst_en,
  input  logic [TAG_W-1:0]       id_dst_tag,
  input  logic                   id_dst_vf,
  input  logic                   id_is_load,
  input  logic [DATA_W-1:0]      s1_res,
  input  logic [DATA_W-1:0]      s2_res,
  output logic [NSRC*DATA_W-1:0] op_data,
  output logic                   stall,
  output logic                   s1_rec_valid,
  output logic                   s2_rec_valid,
  output logic [CNT_W-1:0]       fwd_cnt,
  output logic [CNT_W-1:0]       stall_cnt
);

  dest_rec_t s1_q, s1_d;
  dest_rec_t s2_q, s2_d;
  dest_rec_t w_dec_rec;

  logic [NSRC-1:0] w_s1_load_hit;
  logic [NSRC-1:0] w_fwd;

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    fwd_src_e w_sel;

    fwd_src_sel #(
      .DATA_W (DATA_W)
    ) u_sel (
      .src_en_i      (id_src_en[g]),
      .src_tag_i     (FWD_TAG_MAX'(id_src_tag[g*TAG_W +: TAG_W])),
      .src_vf_i      (id_src_vf[g]),
      .rf_data_i     (id_src_data[g*DATA_W +: DATA_W]),
      .s1_rec_i      (s1_q),
      .s2_rec_i      (s2_q),
      .s1_res_i      (s1_res),
      .s2_res_i      (s2_res),
      .data_o        (op_data[g*DATA_W +: DATA_W]),
      .sel_o         (w_sel),
      .s1_load_hit_o (w_s1_load_hit[g])
    );

    assign w_fwd[g] = (w_sel != FWD_RF);
  end

  // A flush kills the branch shadow, so it must never hold decode.
  assign stall = id_valid & ~flush & (|w_s1_load_hit);

  always_comb begin
    w_dec_rec         = '0;
    w_dec_rec.valid   = id_valid & id_dst_en & (id_dst_tag != '0) & ~stall & ~flush;
    w_dec_rec.tag     = FWD_TAG_MAX'(id_dst_tag);
    w_dec_rec.vf      = id_dst_vf;
    w_dec_rec.is_load = id_is_load;

    s1_d = w_dec_rec;
    s2_d = s1_q;
    if (flush) begin
      s1_d = '0;
      s2_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign s1_rec_valid = s1_q.valid;
  assign s2_rec_valid = s2_q.valid;

`ifdef FWD_PERF_EN
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fwd_cnt_d   = fwd_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if ((|w_fwd) && !stall && (fwd_cnt_q != '1)) begin
      fwd_cnt_d = fwd_cnt_q + 1'b1;
    end
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      fwd_cnt_q   <= fwd_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_cnt   = fwd_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  logic w_unused_fwd;
  assign w_unused_fwd = |w_fwd;
  assign fwd_cnt      = '0;
  assign stall_cnt    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
// ============================================================================
// Module : tb_fwd_hazard_unit
// Brief  : Directed and random checks of fwd_hazard_unit against a history model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fwd_hazard_unit;

  localparam int DATA_W = 128;
  localparam int TAG_W  = 4;
  localparam int NSRC   = 3;
  localparam int CNT_W  = 32;
`ifdef FWD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   flush;
  logic                   id_valid;
  logic [NSRC-1:0]        id_src_en;
  logic [NSRC*TAG_W-1:0]  id_src_tag;
  logic [NSRC-1:0]        id_src_vf;
  logic [NSRC*DATA_W-1:0] id_src_data;
  logic                   id_dst_en;
  logic [TAG_W-1:0]       id_dst_tag;
  logic                   id_dst_vf;
  logic                   id_is_load;
  logic [DATA_W-1:0]      s1_res;
  logic [DATA_W-1:0]      s2_res;
  logic [NSRC*DATA_W-1:0] op_data;
  logic                   stall;
  logic                   s1_rec_valid;
  logic                   s2_rec_valid;
  logic [CNT_W-1:0]       fwd_cnt;
  logic [CNT_W-1:0]       stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W),
    .NSRC   (NSRC),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .id_valid     (id_valid),
    .id_src_en    (id_src_en),
    .id_src_tag   (id_src_tag),
    .id_src_vf    (id_src_vf),
    .id_src_data  (id_src_data),
    .id_dst_en    (id_dst_en),
    .id_dst_tag   (id_dst_tag),
    .id_dst_vf    (id_dst_vf),
    .id_is_load   (id_is_load),
    .s1_res       (s1_res),
    .s2_res       (s2_res),
    .op_data      (op_data),
    .stall        (stall),
    .s1_rec_valid (s1_rec_valid),
    .s2_rec_valid (s2_rec_valid),
    .fwd_cnt      (fwd_cnt),
    .stall_cnt    (stall_cnt)
  );

  // Reference: the two most recently issued writers, youngest first.
  typedef struct {
    bit valid;
    int tag;
    bit vf;
    bit load;
  } mrec_t;

  mrec_t                  hist [2];
  logic [NSRC*DATA_W-1:0] exp_op;
  bit                     exp_stall;
  bit                     exp_any_fwd;
  logic [CNT_W-1:0]       m_fwd;
  logic [CNT_W-1:0]       m_stall;

  function automatic logic [DATA_W-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) hist[k] = '{valid: 1'b0, tag: 0, vf: 1'b0, load: 1'b0};
    m_fwd   = '0;
    m_stall = '0;
  endfunction

  function automatic void model_eval();
    exp_any_fwd = 1'b0;
    exp_stall   = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      logic [DATA_W-1:0] v;
      int                t;
      v = id_src_data[i*DATA_W +: DATA_W];
      t = int'(id_src_tag[i*TAG_W +: TAG_W]);
      for (int k = 0; k < 2; k++) begin
        if (id_src_en[i] && t != 0 && hist[k].valid && hist[k].tag == t && hist[k].vf == id_src_vf[i]) begin
          v = (k == 0) ? s1_res : s2_res;
          exp_any_fwd = 1'b1;
          if (k == 0 && hist[0].load && id_valid && !flush) exp_stall = 1'b1;
          break;
        end
      end
      exp_op[i*DATA_W +: DATA_W] = v;
    end
  endfunction

  function automatic void model_advance();
    mrec_t n;
    if (exp_any_fwd && !exp_stall) m_fwd = m_fwd + 1;
    if (exp_stall) m_stall = m_stall + 1;
    n.valid = id_valid && id_dst_en && (id_dst_tag != 0) && !exp_stall && !flush;
    n.tag   = int'(id_dst_tag);
    n.vf    = id_dst_vf;
    n.load  = id_is_load;
    if (flush) begin
      hist[0].valid = 1'b0;
      hist[1].valid = 1'b0;
    end else begin
      hist[1] = hist[0];
      hist[0] = n;
    end
  endfunction

  task automatic tb_cycle();
    model_eval();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic set_idle();
    flush       = 1'b0;
    id_valid    = 1'b0;
    id_src_en   = '0;
    id_src_tag  = '0;
    id_src_vf   = '0;
    for (int i = 0; i < NSRC; i++) id_src_data[i*DATA_W +: DATA_W] = rnd_data();
    id_dst_en   = 1'b0;
    id_dst_tag  = '0;
    id_dst_vf   = 1'b0;
    id_is_load  = 1'b0;
    s1_res      = rnd_data();
    s2_res      = rnd_data();
  endtask

  task automatic set_src(input int i, input bit en, input int tag, input bit vf);
    id_valid                     = 1'b1;
    id_src_en[i]                 = en;
    id_src_tag[i*TAG_W +: TAG_W] = TAG_W'(tag);
    id_src_vf[i]                 = vf;
  endtask

  task automatic set_dst(input bit en, input int tag, input bit vf, input bit load);
    id_valid   = 1'b1;
    id_dst_en  = en;
    id_dst_tag = TAG_W'(tag);
    id_dst_vf  = vf;
    id_is_load = load;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_idle();
    set_src(0, 1'b1, 3, 1'b0);
    model_reset();
    #3;
    checks++;
    if (s1_rec_valid !== 1'b0 || s2_rec_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_recs: got s1=%b s2=%b, want 0 0", s1_rec_valid, s2_rec_valid);
    end
    checks++;
    if (stall !== 1'b0 || op_data !== id_src_data) begin
      errors++;
      $display("FAIL reset_out: got stall=%b op=%h, want stall=0 op=%h", stall, op_data, id_src_data);
    end
    checks++;
    if (fwd_cnt !== '0 || stall_cnt !== '0) begin
      errors++;
      $display("FAIL reset_cnt: got fwd=%0d stall=%0d, want 0 0", fwd_cnt, stall_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_idle();
    tb_cycle();
  endtask

  task automatic test_alu_chain();
    logic [DATA_W-1:0] aa;
    aa = {16{8'hAA}};
    set_idle();
    set_dst(1'b1, 3, 1'b1, 1'b0);
    tb_cycle();
    set_idle();
    set_src(0, 1'b1, 3, 1'b1);
    s1_res = aa;
    @(negedge clk);
    model_eval();
    checks++;
    if (op_data[DATA_W-1:0] !== aa || stall !== 1'b0) begin
      errors++;
      $display("FAIL alu_chain: got op0=%h stall=%b, want op0=%h stall=0", op_data[DATA_W-1:0], stall, aa);
    end
    checks++;
    if (op_data !== exp_op) begin
      errors++;
      $display("FAIL alu_chain_all: got %h, want %h", op_data, exp_op);
    end
    tb_cycle();
  endtask

  task automatic test_distance2();
    logic [DATA_W-1:0] v55;
    v55 = DATA_W'(8'h55);
    set_idle();
    set_dst(1'b1, 5, 1'b0, 1'b0);
    tb_cycle();
    set_idle();
    tb_cycle();
    set_idle();
    set_src(1, 1'b1, 5, 1'b0);
    s2_res = v55;
    @(negedge clk);
    model_eval();
    checks++;
    if (op_data[DATA_W +: DATA_W] !== v55 || op_data !== exp_op) begin
      errors++;
      $display("FAIL dist2: got op=%h, want op1=%h all=%h", op_data, v55, exp_op);
    end
    tb_cycle();
    set_idle();
    set_dst(1'b1, 6, 1'b0, 1'b0);
    tb_cycle();
    set_idle();
    set_dst(1'b1, 6, 1'b0, 1'b0);
    tb_cycle();
    set_idle();
    set_src(2, 1'b1, 6, 1'b0);
    @(negedge clk);
    model_eval();
    checks++;
    if (op_data[2*DATA_W +: DATA_W] !== s1_res || op_data !== exp_op) begin
      errors++;
      $display("FAIL same_tag_s1_wins: got op2=%h, want %h", op_data[2*DATA_W +: DATA_W], s1_res);
    end
    tb_cycle();
  endtask

  task automatic test_load_use();
    set_idle();
    set_dst(1'b1, 7, 1'b0, 1'b1);
    tb_cycle();
    set_idle();
    set_src(1, 1'b1, 7, 1'b0);
    @(negedge clk);
    model_eval();
    checks++;
    if (stall !== 1'b1 || stall !== exp_stall) begin
      errors++;
      $display("FAIL load_use_stall: got %b, want 1", stall);
    end
    tb_cycle();
    @(negedge clk);
    model_eval();
    checks++;
    if (stall !== 1'b0 || s1_rec_valid !== 1'b0 || s2_rec_valid !== 1'b1) begin
      errors++;
      $display("FAIL load_use_after: got stall=%b s1v=%b s2v=%b, want 0 0 1", stall, s1_rec_valid, s2_rec_valid);
    end
    checks++;
    if (op_data[DATA_W +: DATA_W] !== s2_res || op_data !== exp_op) begin
      errors++;
      $display("FAIL load_use_fwd: got op1=%h, want %h", op_data[DATA_W +: DATA_W], s2_res);
    end
    tb_cycle();
  endtask

  task automatic test_tag0_vf();
    set_idle();
    set_dst(1'b1, 0, 1'b0, 1'b0);
    tb_cycle();
    set_idle();
    set_src(0, 1'b1, 0, 1'b0);
    @(negedge clk);
    checks++;
    if (op_data !== id_src_data || stall !== 1'b0) begin
      errors++;
      $display("FAIL tag0: got op=%h stall=%b, want op=%h stall=0", op_data, stall, id_src_data);
    end
    tb_cycle();
    set_idle();
    set_dst(1'b1, 4, 1'b0, 1'b1);
    tb_cycle();
    set_idle();
    set_src(0, 1'b1, 4, 1'b1);
    @(negedge clk);
    checks++;
    if (op_data !== id_src_data || stall !== 1'b0) begin
      errors++;
      $display("FAIL vf_mismatch: got op=%h stall=%b, want op=%h stall=0", op_data, stall, id_src_data);
    end
    tb_cycle();
  endtask

  task automatic test_flush();
    set_idle();
    set_dst(1'b1, 9, 1'b0, 1'b1);
    tb_cycle();
    set_idle();
    set_src(0, 1'b1, 9, 1'b0);
    set_dst(1'b1, 10, 1'b0, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: got %b, want 0", stall);
    end
    tb_cycle();
    set_idle();
    @(negedge clk);
    checks++;
    if (s1_rec_valid !== 1'b0 || s2_rec_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_recs: got s1=%b s2=%b, want 0 0", s1_rec_valid, s2_rec_valid);
    end
    tb_cycle();
  endtask

  task automatic test_async_reset();
    set_idle();
    set_dst(1'b1, 11, 1'b1, 1'b0);
    tb_cycle();
    set_idle();
    set_dst(1'b1, 12, 1'b0, 1'b1);
    tb_cycle();
    set_idle();
    set_src(0, 1'b1, 12, 1'b0);
    set_src(1, 1'b1, 11, 1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (s1_rec_valid !== 1'b0 || s2_rec_valid !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL async_rst_recs: got s1=%b s2=%b stall=%b, want 0 0 0", s1_rec_valid, s2_rec_valid, stall);
    end
    checks++;
    if (fwd_cnt !== '0 || stall_cnt !== '0) begin
      errors++;
      $display("FAIL async_rst_cnt: got fwd=%0d stall=%0d, want 0 0", fwd_cnt, stall_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (op_data !== id_src_data) begin
      errors++;
      $display("FAIL async_rst_stale: got %h, want %h", op_data, id_src_data);
    end
    tb_cycle();
  endtask

  task automatic test_perf();
    set_idle();
    set_dst(1'b1, 2, 1'b0, 1'b0);
    tb_cycle();
    set_idle();
    set_src(0, 1'b1, 2, 1'b0);
    set_dst(1'b1, 3, 1'b0, 1'b1);
    tb_cycle();
    set_idle();
    set_src(0, 1'b1, 3, 1'b0);
    set_dst(1'b1, 5, 1'b0, 1'b0);
    tb_cycle();
    tb_cycle();
    set_idle();
    set_src(2, 1'b1, 5, 1'b0);
    tb_cycle();
    set_idle();
    @(negedge clk);
    checks++;
    if (fwd_cnt !== (PERF ? CNT_W'(3) : '0) || stall_cnt !== (PERF ? CNT_W'(1) : '0)) begin
      errors++;
      $display("FAIL perf_cnt: got fwd=%0d stall=%0d, want %0d %0d",
               fwd_cnt, stall_cnt, PERF ? 3 : 0, PERF ? 1 : 0);
    end
    tb_cycle();
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 400; c++) begin
      flush     = ($urandom_range(15) == 0);
      id_valid  = ($urandom_range(7) != 0);
      for (int i = 0; i < NSRC; i++) begin
        id_src_en[i]                    = $urandom_range(1);
        id_src_tag[i*TAG_W +: TAG_W]    = TAG_W'($urandom_range(3));
        id_src_vf[i]                    = ($urandom_range(3) == 0);
        id_src_data[i*DATA_W +: DATA_W] = rnd_data();
      end
      id_dst_en  = $urandom_range(1);
      id_dst_tag = TAG_W'($urandom_range(3));
      id_dst_vf  = ($urandom_range(3) == 0);
      id_is_load = ($urandom_range(2) == 0);
      s1_res     = rnd_data();
      s2_res     = rnd_data();
      @(negedge clk);
      model_eval();
      checks++;
      if (op_data !== exp_op || stall !== exp_stall ||
          s1_rec_valid !== hist[0].valid || s2_rec_valid !== hist[1].valid ||
          fwd_cnt !== (PERF ? m_fwd : '0) || stall_cnt !== (PERF ? m_stall : '0)) begin
        errors++;
        bad++;
        if (bad <= 5)
          $display("FAIL random[%0d]: got stall=%b s1v=%b s2v=%b fc=%0d sc=%0d op=%h, want %b %b %b %0d %0d %h",
                   c, stall, s1_rec_valid, s2_rec_valid, fwd_cnt, stall_cnt, op_data,
                   exp_stall, hist[0].valid, hist[1].valid, PERF ? m_fwd : '0, PERF ? m_stall : '0, exp_op);
      end
      tb_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_distance2();
    test_load_use();
    test_tag0_vf();
    test_flush();
    test_async_reset();
    test_perf();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
